// File: rtl/pico_pkg.sv
// Shared types and constants for the pico register-file write path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pico_pkg;

  localparam int pico_N       = 8;   // data width
  localparam int pico_R       = 32;  // register count
  localparam int PICO_AW      = 5;   // register address width
  localparam int PICO_EXT_REG = 30;  // externally driven register index

  // One register-file write: destination and payload.
  typedef struct packed {
    logic [PICO_AW-1:0] addr;
    logic [pico_N-1:0]  data;
  } rf_wr_t;

  typedef enum logic {
    CORE_PRI = 1'b0,
    FORCE    = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding queued debug register writes.
// Latency: an entry pushed at edge t is visible on head_o during cycle t+1.
// Backpressure: pushes are ignored while full, pops ignored while empty; no full bypass.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset (empties the FIFO)
//   push_i/push_dat_i   write request and payload
//   pop_i               consume head entry
//   head_o              current head entry (valid when !empty_o)
//   full_o/empty_o      occupancy flags
module rf_wr_fifo
  import pico_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   push_i,
  input  rf_wr_t push_dat_i,
  input  logic   pop_i,
  output rf_wr_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  rf_wr_t        mem [DEPTH];
  // One extra MSB distinguishes full from empty when the index bits match.
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head_o  = mem[rd_ptr[PW-1:0]];

  // Full is checked before any same-cycle pop, so a full FIFO never accepts.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Shares the register-file write port between core writeback (priority) and a debug FIFO.
// Latency: core grant -> rf write 1 cycle; debug push -> rf write 2 cycles minimum.
// Backpressure: wb_ready_o drops for one forced-debug cycle; dbg_ready_o drops while FIFO full.
//
// Ports:
//   clk_i, rst_n_i                        clock, synchronous active-low reset
//   wb_valid_i/wb_addr_i/wb_data_i        core write request (held while wb_ready_o = 0)
//   wb_ready_o                            core request accepted this cycle (state only)
//   dbg_valid_i/dbg_addr_i/dbg_data_i     debug write request into the FIFO
//   dbg_ready_o, dbg_pending_o            FIFO not full / FIFO not empty
//   rf_wr_en_o/rf_addr_o/rf_data_o        registered register-file write port
//   prot_err_o                            one-cycle pulse when a protected write is dropped
module rf_wr_arb
  import pico_pkg::*;
#(
  parameter  int N          = pico_N,
  parameter  int R          = pico_R,
  parameter  int DEPTH      = 2,
  parameter  int STARVE_LIM = 4,
  parameter  int EXT_REG    = PICO_EXT_REG,
  localparam int AW         = $clog2(R)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [N-1:0]  wb_data_i,
  output logic          wb_ready_o,
  input  logic          dbg_valid_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [N-1:0]  dbg_data_i,
  output logic          dbg_ready_o,
  output logic          rf_wr_en_o,
  output logic [AW-1:0] rf_addr_o,
  output logic [N-1:0]  rf_data_o,
  output logic          prot_err_o,
  output logic          dbg_pending_o
);

  localparam logic [3:0]    LIM      = 4'(STARVE_LIM);
  localparam logic [AW-1:0] EXT_ADDR = AW'(EXT_REG);

  arb_state_t    state;
  logic [3:0]    starve_cnt;
  logic [3:0]    starve_nxt;

  rf_wr_t        dbg_req;
  rf_wr_t        dbg_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          dbg_push;

  logic          grant_core;
  logic          grant_dbg;
  logic          grant;
  logic          drop;
  logic [AW-1:0] sel_addr;
  logic [N-1:0]  sel_data;

  assign dbg_req       = '{addr: dbg_addr_i, data: dbg_data_i};
  assign dbg_push      = dbg_valid_i && !fifo_full;
  assign dbg_ready_o   = !fifo_full;
  assign dbg_pending_o = !fifo_empty;
  assign wb_ready_o    = (state == CORE_PRI);

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (dbg_push),
    .push_dat_i (dbg_req),
    .pop_i      (grant_dbg),
    .head_o     (dbg_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    grant_core = (state == CORE_PRI) && wb_valid_i;
    // Debug wins when forced, or when the core leaves the port idle.
    grant_dbg  = !fifo_empty && ((state == FORCE) || !wb_valid_i);
    grant      = grant_core || grant_dbg;
    sel_addr   = grant_core ? wb_addr_i : dbg_head.addr;
    sel_data   = grant_core ? wb_data_i : dbg_head.data;
    drop       = (sel_addr == '0) || (sel_addr == EXT_ADDR);

    // Counts only core wins while debug waits; every other case (debug grant,
    // forced cycle, empty FIFO) clears it. Since it never moves while the FIFO
    // is empty, FORCE always finds a head entry to pop.
    starve_nxt = '0;
    if (grant_core && !fifo_empty) starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= CORE_PRI;
      starve_cnt <= '0;
      rf_wr_en_o <= 1'b0;
      prot_err_o <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      case (state)
        CORE_PRI: if (starve_nxt == LIM) state <= FORCE;
        FORCE:    state <= CORE_PRI;
        default:  state <= CORE_PRI;
      endcase

      rf_wr_en_o <= grant && !drop;
      prot_err_o <= grant && drop;
      // Idle and dropped cycles leave the last real write's address/data visible.
      if (grant && !drop) begin
        rf_addr_o <= sel_addr;
        rf_data_o <= sel_data;
      end
    end
  end

endmodule
